// File: rtl/register_file_sb.sv
// Parametrised multi-read-port register file with a per-register pending scoreboard.
// Optional write-through forwarding to the read ports is enabled by defining REGFILE_BYPASS_EN.
module register_file_sb #(
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 5,
  parameter int NREAD  = 2
) (
  input  logic                      CLOCK,
  input  logic                      RESET_N,
  input  logic [NREAD*ADDR_W-1:0]   RA,
  output logic [NREAD*WIDTH-1:0]    RD,
  output logic [NREAD-1:0]          RBUSY,
  output logic                      STALL,
  input  logic                      WE,
  input  logic [ADDR_W-1:0]         WA,
  input  logic [WIDTH-1:0]          WD,
  input  logic                      RSV,
  input  logic [ADDR_W-1:0]         RSV_A
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DEPTH-1:0][WIDTH-1:0] mem_q, mem_d;
  logic [DEPTH-1:0]            pend_q, pend_d;
  logic                        wr_en;
  logic                        rsv_en;

  assign wr_en  = WE && (WA != '0);
  assign rsv_en = RSV && (RSV_A != '0);

  // Reserve is applied after the retiring write so a same-address collision leaves the bit set.
  always_comb begin
    mem_d  = mem_q;
    pend_d = pend_q;
    if (wr_en) begin
      mem_d[WA]  = WD;
      pend_d[WA] = 1'b0;
    end
    if (rsv_en) begin
      pend_d[RSV_A] = 1'b1;
    end
  end

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      mem_q  <= '0;
      pend_q <= '0;
    end else begin
      mem_q  <= mem_d;
      pend_q <= pend_d;
    end
  end

  for (genvar i = 0; i < NREAD; i++) begin : g_rport
    logic [ADDR_W-1:0] ra;
    assign ra = RA[i*ADDR_W +: ADDR_W];
`ifdef REGFILE_BYPASS_EN
    logic fwd;
    assign fwd = wr_en && (ra == WA);
    assign RD[i*WIDTH +: WIDTH] = fwd ? WD
                                : ((ra == '0) ? '0 : mem_q[ra]);
    assign RBUSY[i] = fwd ? (RSV && (RSV_A == WA)) : pend_q[ra];
`else
    assign RD[i*WIDTH +: WIDTH] = (ra == '0) ? '0 : mem_q[ra];
    assign RBUSY[i] = pend_q[ra];
`endif
  end

  assign STALL = |RBUSY;

endmodule

// File: tb/tb_register_file_sb.sv
// Self-checking bench for register_file_sb: directed steps, randomized traffic against a
// behavioural register/scoreboard model, and a second instance with a 32-bit, 8-entry, 3-port shape.
module tb_register_file_sb;
  localparam int W  = 8;
  localparam int AW = 5;
  localparam int NR = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n;
  logic [NR*AW-1:0]  ra;
  logic [NR*W-1:0]   rd;
  logic [NR-1:0]     rbusy;
  logic              stall;
  logic              we;
  logic [AW-1:0]     wa;
  logic [W-1:0]      wd;
  logic              rsv;
  logic [AW-1:0]     rsv_a;

  register_file_sb #(.WIDTH(W), .ADDR_W(AW), .NREAD(NR)) dut (
    .CLOCK(clk), .RESET_N(rst_n), .RA(ra), .RD(rd), .RBUSY(rbusy), .STALL(stall),
    .WE(we), .WA(wa), .WD(wd), .RSV(rsv), .RSV_A(rsv_a)
  );

  logic [8:0]  s_ra;
  logic [95:0] s_rd;
  logic [2:0]  s_rbusy;
  logic        s_stall;
  logic        s_we;
  logic [2:0]  s_wa;
  logic [31:0] s_wd;
  logic        s_rsv;
  logic [2:0]  s_rsv_a;

  register_file_sb #(.WIDTH(32), .ADDR_W(3), .NREAD(3)) dut_w (
    .CLOCK(clk), .RESET_N(rst_n), .RA(s_ra), .RD(s_rd), .RBUSY(s_rbusy), .STALL(s_stall),
    .WE(s_we), .WA(s_wa), .WD(s_wd), .RSV(s_rsv), .RSV_A(s_rsv_a)
  );

  int vectors     = 0;
  int miscompares = 0;

  logic [W-1:0] m_mem  [32];
  logic         m_pend [32];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < 32; k++) begin
      m_mem[k]  = '0;
      m_pend[k] = 1'b0;
    end
  endtask

  task automatic drive(input logic i_we, input logic [AW-1:0] i_wa, input logic [W-1:0] i_wd,
                       input logic i_rsv, input logic [AW-1:0] i_rsv_a,
                       input logic [AW-1:0] i_ra0, input logic [AW-1:0] i_ra1);
    @(negedge clk);
    we = i_we; wa = i_wa; wd = i_wd; rsv = i_rsv; rsv_a = i_rsv_a;
    ra = {i_ra1, i_ra0};
    #1;
  endtask

  task automatic check_model(input string tag);
    logic [AW-1:0] a;
    logic [W-1:0]  er;
    logic          eb;
    logic [NR-1:0] ebv;
    ebv = '0;
    for (int i = 0; i < NR; i++) begin
      a  = ra[i*AW +: AW];
      er = (a == 0) ? '0 : m_mem[a];
      eb = m_pend[a];
`ifdef REGFILE_BYPASS_EN
      if (we && wa != 0 && a == wa) begin
        er = wd;
        eb = rsv && (rsv_a == wa);
      end
`endif
      ebv[i] = eb;
      chk($sformatf("%s_rd%0d", tag, i), rd[i*W +: W], er);
      chk($sformatf("%s_busy%0d", tag, i), rbusy[i], eb);
    end
    chk($sformatf("%s_stall", tag), stall, |ebv);
  endtask

  task automatic edge_update();
    @(posedge clk);
    if (rst_n) begin
      if (we && wa != 0) begin
        m_mem[wa]  = wd;
        m_pend[wa] = 1'b0;
      end
      if (rsv && rsv_a != 0) m_pend[rsv_a] = 1'b1;
    end
  endtask

  function automatic logic [AW-1:0] raddr();
    if ($urandom_range(0, 1) == 1) return AW'($urandom_range(0, 7));
    return AW'($urandom_range(0, 31));
  endfunction

  initial begin
    logic [2:0] a3;
    rst_n = 1'b0;
    we = 0; wa = '0; wd = '0; rsv = 0; rsv_a = '0; ra = '0;
    s_we = 0; s_wa = '0; s_wd = '0; s_rsv = 0; s_rsv_a = '0; s_ra = '0;
    model_clear();
    #12;
    chk("rst_rd", rd, '0);
    chk("rst_busy", rbusy, '0);
    chk("rst_stall", stall, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // write then read back on both ports
    drive(1, 7, 8'h5C, 0, 0, 0, 0); check_model("w7"); edge_update();
    drive(0, 0, 0, 0, 0, 7, 7);
    chk("rd7_p0", rd[7:0], 8'h5C);
    chk("rd7_p1", rd[15:8], 8'h5C);
    edge_update();

    // register 0 stays zero
    drive(1, 0, 8'hFF, 0, 0, 0, 0); check_model("w0"); edge_update();
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("r0_p0", rd[7:0], 8'h00);
    chk("r0_p1", rd[15:8], 8'h00);
    edge_update();

    // reserve then retire
    drive(0, 0, 0, 1, 9, 0, 0); edge_update();
    drive(0, 0, 0, 0, 0, 0, 9);
    chk("sb9_busy", rbusy[1], 1'b1);
    chk("sb9_stall", stall, 1'b1);
    edge_update();
    drive(1, 9, 8'h11, 0, 0, 0, 9); check_model("sb9_wr"); edge_update();
    drive(0, 0, 0, 0, 0, 0, 9);
    chk("sb9_clr", rbusy[1], 1'b0);
    chk("sb9_rd", rd[15:8], 8'h11);
    edge_update();

    // same-address reserve and write
    drive(1, 4, 8'h33, 1, 4, 4, 0); check_model("cf4"); edge_update();
    drive(0, 0, 0, 0, 0, 4, 0);
    chk("cf4_rd", rd[7:0], 8'h33);
    chk("cf4_busy", rbusy[0], 1'b1);
    edge_update();
    drive(1, 4, 8'h44, 0, 0, 0, 0); edge_update();
    drive(0, 0, 0, 0, 0, 4, 0);
    chk("cf4_clr", rbusy[0], 1'b0);
    chk("cf4_rd2", rd[7:0], 8'h44);
    edge_update();

    // same-cycle read of the write address
    drive(1, 2, 8'h10, 0, 0, 0, 0); edge_update();
    drive(1, 2, 8'h20, 0, 0, 2, 0);
`ifdef REGFILE_BYPASS_EN
    chk("byp_pre", rd[7:0], 8'h20);
`else
    chk("byp_pre", rd[7:0], 8'h10);
`endif
    check_model("byp");
    edge_update();
    drive(0, 0, 0, 0, 0, 2, 0);
    chk("byp_post", rd[7:0], 8'h20);
    edge_update();

    // randomized traffic
    repeat (400) begin
      drive(($urandom_range(0, 2) != 0), raddr(), W'($urandom),
            ($urandom_range(0, 2) == 0), raddr(), raddr(), raddr());
      check_model("rnd");
      edge_update();
    end

    // asynchronous reset mid-cycle
    drive(1, 3, 8'hA5, 0, 0, 0, 0); edge_update();
    drive(0, 0, 0, 1, 3, 0, 0); edge_update();
    drive(0, 0, 0, 0, 0, 3, 3);
    chk("pre_rst_busy", rbusy[0], 1'b1);
    chk("pre_rst_rd", rd[7:0], 8'hA5);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_rd", rd, '0);
    chk("arst_busy", rbusy, '0);
    chk("arst_stall", stall, 1'b0);
    model_clear();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    drive(0, 0, 0, 0, 0, 3, 3);
    check_model("post_rst");
    edge_update();

    // wide instance: fill all entries, reserve r0, read three addresses per cycle
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      s_we = 1'b1; s_wa = 3'(n); s_wd = 32'h1000_0000 + n;
    end
    @(negedge clk);
    s_we = 1'b0; s_rsv = 1'b1; s_rsv_a = 3'd0;
    @(negedge clk);
    s_rsv = 1'b0;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      s_ra = {3'(n + 2), 3'(n + 1), 3'(n)};
      #1;
      for (int k = 0; k < 3; k++) begin
        a3 = s_ra[k*3 +: 3];
        chk($sformatf("sw_rd%0d_%0d", n, k), s_rd[k*32 +: 32],
            (a3 == 0) ? 32'h0 : (32'h1000_0000 + 32'(a3)));
      end
      chk($sformatf("sw_busy%0d", n), s_rbusy, 3'b000);
      chk($sformatf("sw_stall%0d", n), s_stall, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/register_file_sb.md
# register_file_sb

Parametrised multi-read-port register file with a per-register pending scoreboard, for the MIPS datapath decode stage. It generalises the fixed 8-bit, 32-entry, two-read/one-write register file in three ways: width, depth and read-port count are parameters; register 0 is hardwired to zero; and each register carries a pending bit. A pending bit is set when a long-latency producer reserves the register and cleared when that producer's write retires, so decode can stall on read-after-write hazards without external tracking.

## Interface
Parameters:
- WIDTH, 8, data width in bits
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W entries
- NREAD, 2, number of read ports (1..4)

Ports:
- CLOCK  input  1  single clock; all state updates on the rising edge
- RESET_N  input  1  reset, asynchronous, active-low
- RA  input  NREAD*ADDR_W  read addresses; port i uses RA[i*ADDR_W +: ADDR_W]
- RD  output  NREAD*WIDTH  read data; port i uses RD[i*WIDTH +: WIDTH]
- RBUSY  output  NREAD  port i is 1 when register RA[i] is pending
- STALL  output  1  OR of all RBUSY bits
- WE  input  1  write enable
- WA  input  ADDR_W  write address
- WD  input  WIDTH  write data
- RSV  input  1  reserve: set the pending bit of RSV_A
- RSV_A  input  ADDR_W  reserve address

## Operation
- Storage:
  - DEPTH x WIDTH data array.
  - DEPTH pending bits, pend[0..DEPTH-1].
- Reset (RESET_N=0, asynchronous):
  - All data entries and all pending bits clear to 0 immediately.
  - Outputs during and after reset: RD=0, RBUSY=0, STALL=0.
  - An assertion of RESET_N in the middle of operation discards all reservations and data.
- Write, on the edge with WE=1 and WA!=0:
  - mem[WA] <= WD.
  - pend[WA] <= 0.
  - A write with WA=0 is ignored.
- Reserve, on the edge with RSV=1 and RSV_A!=0:
  - pend[RSV_A] <= 1.
  - A reserve with RSV_A=0 is ignored; register 0 is never pending.
- Reserve and write in the same cycle:
  - Same address: reserve wins, so pend ends at 1 and the data is still written (the older producer retires, a newer one is in flight).
  - Different addresses: both take effect.
- Reserving an already-pending register is legal; the bit stays 1. There is no producer count.
- Writing a non-pending register is legal; it is an ordinary write.
- Reads are combinational from RA:
  - RD[i] = mem[RA[i]], or 0 when RA[i]=0.
  - RBUSY[i] = pend[RA[i]].
- Read ports are independent. Any ports may share an address.

## Timing
- Read latency: 0 cycles (combinational).
- Write and reserve effects are visible to reads after the rising edge that samples them.
- Without bypass, a read of WA in the same cycle as the write returns the old value and the old pending bit.
- RESET_N deassertion is synchronised externally. The block needs no internal reset-release sequencing.
- There is no handshake: WE and RSV are single-cycle, one-shot commands per edge.

## Configuration
- REGFILE_BYPASS_EN defined: write-through forwarding.
  - Condition: WE=1, WA!=0 and RA[i]==WA.
  - RD[i] = WD combinationally in that same cycle.
  - RBUSY[i] = 0 unless RSV=1 and RSV_A==WA in that cycle, in which case RBUSY[i] = 1.
  - Cost: adds an NREAD-wide comparator and mux path from WD to RD.
- REGFILE_BYPASS_EN undefined: no forwarding. Same-cycle reads see pre-edge state; the datapath inserts its own forwarding or a stall.

## Test plan
- Reset: pulse RESET_N low mid-clock after writing mem[3]=0xA5 and reserving r3 -> immediately RD=0 for RA=3, RBUSY=0, STALL=0, with no clock edge needed.
- Write/read: WE=1, WA=7, WD=0x5C, then next cycle RA[0]=7, RA[1]=7 -> both ports 0x5C. Writes of WA=0, WD=0xFF -> RA=0 always reads 0x00.
- Scoreboard: RSV=1, RSV_A=9 -> next cycle RA[1]=9 gives RBUSY[1]=1, STALL=1. Then WE=1, WA=9, WD=0x11 -> next cycle RBUSY[1]=0, RD[1]=0x11.
- Same-cycle conflict: RSV=1, RSV_A=4 together with WE=1, WA=4, WD=0x33 -> next cycle RD=0x33, RBUSY=1. A second write to r4 -> RBUSY=0.
- Bypass, with REGFILE_BYPASS_EN: mem[2]=0x10, then WE=1, WA=2, WD=0x20 with RA[0]=2 in the same cycle -> RD[0]=0x20 before the edge. Without the macro -> RD[0]=0x10 before the edge and 0x20 after.
- Parameter sweep: WIDTH=32, ADDR_W=3, NREAD=3 -> write all 8 entries with value 0x1000_0000+n, then read three distinct addresses per cycle, all correct. Reserving r0 never raises RBUSY.
